bmu_wb_queue: RTL and testbench
===============================

// Module: bmu_wb_queue
// PURPOSE
//  Writeback stage directly downstream of Bit_Manibulation_Unit.
//  Pairs each BMU issue (valid_in + destination tag) with the registered result_ff/error LAT cycles later.
//  Queues the pair in a DEPTH-entry FIFO and presents it to the register-file writeback arbiter
//  over a valid/ready handshake; issue_ready back-pressures the issue stage via credits.
// PARAMETERS
//  WIDTH  32  result datapath width (matches BMU result_ff)
//  TAGW   5   destination register tag width
//  LAT    1   cycles from BMU valid_in to result_ff valid (>=1)
//  DEPTH  4   FIFO entries (power of two, >=2)
// PORTS
//  clk          in   1      clock
//  rst          in   1      reset: one clock clk; reset rst is synchronous and active-high
//  valid_in     in   1      BMU issue strobe (same signal driven to BMU valid_in)
//  rd_in        in   TAGW   destination tag of the issued op, sampled with valid_in
//  result_ff    in   WIDTH  BMU registered result
//  error        in   1      BMU error flag, aligned with result_ff
//  issue_ready  out  1      credit available; upstream issues only when high
//  wb_valid     out  1      FIFO head valid
//  wb_ready     in   1      arbiter accepts head
//  wb_data      out  WIDTH  head result
//  wb_rd        out  TAGW   head destination tag
//  wb_error     out  1      head error flag
//  err_cnt      out  8      saturating count of enqueued error results
//  ovf          out  1      sticky: valid_in seen while issue_ready low
// BEHAVIOUR
//  Reset (rst=1 at posedge): tag pipe valids=0, FIFO empty, wb_valid=0, wb_data=0, wb_rd=0,
//   wb_error=0, err_cnt=0, ovf=0, issue_ready=1 the cycle after. Reset mid-op discards all in-flight ops.
//  Tag pipe: LAT-stage shift register of {v, rd}; stage0 loads {valid_in & issue_ready, rd_in}.
//   At the last stage, when v=1, result_ff/error are sampled as that op's result.
//  Enqueue: last-stage v=1 and rd!=0 -> push {result_ff, rd, error}. rd==0 -> result discarded,
//   no push; error on a discarded op still increments err_cnt.
//  Dequeue: wb_valid & wb_ready -> pop. Outputs come from the head entry (registered, no comb path from wb_ready).
//   Head holds stable while wb_valid & !wb_ready.
//  Credits: issue_ready = (fifo_count + inflight) < DEPTH, inflight = popcount of pipe valids.
//   Computed from registered state only. The pop of the current cycle does not count (no same-cycle credit return).
//  Protocol violation: valid_in & !issue_ready -> op dropped (not entered in pipe), ovf<=1 until reset.
//  Simultaneous push & pop: allowed at any count including full; count unchanged. Push when full cannot occur (credits).
//  Pointers: log2(DEPTH)-bit rd/wr pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
//  err_cnt: +1 per error at pipe output (kept or discarded), saturates at 255, no wrap.
//  Throughput: 1 op/cycle sustained when wb_ready=1. Latency valid_in -> wb_valid = LAT+1 cycles.
// TESTING
//  T1 reset then valid_in=1 rd_in=5 BMU result 32'hDEAD_BEEF, wb_ready=1 -> wb_valid at cycle LAT+1, wb_data=DEADBEEF wb_rd=5 wb_error=0, one beat.
//  T2 wb_ready=0, issue 4 ops rd=1..4 -> issue_ready low after 4th issue; release wb_ready -> pops in order 1,2,3,4, issue_ready returns 1 cycle after first pop.
//  T3 issue rd=0 with error=1 -> no wb_valid, err_cnt=1; issue rd=7 error=1 -> wb_error=1, err_cnt=2.
//  T4 full FIFO, wb_ready=1 while last-stage push -> count stays 4, order preserved, no loss.
//  T5 force valid_in while issue_ready=0 -> op absent from output, ovf=1 sticky; 300 error ops -> err_cnt=255.
//  T6 assert rst with 3 ops in flight/queued -> next cycle wb_valid=0, issue_ready=1, err_cnt=0, ovf=0.

Source files
------------

// File: rtl/bmu_wb_queue.sv
// BMU writeback queue: pairs issue tags with delayed BMU results,
// buffers them in a small FIFO and hands them to the regfile arbiter.
module bmu_wb_queue #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5,
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [TAGW-1:0]  rd_in,
  input  logic [WIDTH-1:0] result_ff,
  input  logic             error,
  output logic             issue_ready,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [WIDTH-1:0] wb_data,
  output logic [TAGW-1:0]  wb_rd,
  output logic             wb_error,
  output logic [7:0]       err_cnt,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [TAGW-1:0]  rd;
    logic             err;
  } wb_ent_t;

  logic [LAT-1:0]  pv;
  logic [TAGW-1:0] prd [LAT];
  wb_ent_t         mem [DEPTH];
  wb_ent_t         head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            accept;
  logic            last_v;
  logic            push;
  logic            pop;

  // Credits count queued plus in-flight ops, so a push never finds the FIFO full.
  assign issue_ready = (int'(count) + $countones(pv)) < DEPTH;
  assign accept      = valid_in & issue_ready;
  assign last_v      = pv[LAT-1];
  assign push        = last_v && (prd[LAT-1] != '0);
  assign wb_valid    = (count != '0);
  assign pop         = wb_valid & wb_ready;

  assign head     = mem[rd_ptr];
  assign wb_data  = wb_valid ? head.data : '0;
  assign wb_rd    = wb_valid ? head.rd : '0;
  assign wb_error = wb_valid ? head.err : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) begin
        prd[i] <= '0;
      end
    end else begin
      pv[0]  <= accept;
      prd[0] <= rd_in;
      for (int i = 1; i < LAT; i++) begin
        pv[i]  <= pv[i-1];
        prd[i] <= prd[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{data: result_ff, rd: prd[LAT-1], err: error};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Errors are counted even when the op's result is discarded (rd==0).
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      if (last_v && error && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      if (valid_in && !issue_ready) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bmu_wb_queue.sv
// Bench for bmu_wb_queue: table vectors, directed corner sequences and
// random traffic checked against a queue-based reference model.
module tb_bmu_wb_queue;

  localparam int WIDTH = 32;
  localparam int TAGW  = 5;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_in;
  logic [TAGW-1:0]  rd_in;
  logic [WIDTH-1:0] result_ff;
  logic             error;
  logic             issue_ready;
  logic             wb_valid;
  logic             wb_ready;
  logic [WIDTH-1:0] wb_data;
  logic [TAGW-1:0]  wb_rd;
  logic             wb_error;
  logic [7:0]       err_cnt;
  logic             ovf;

  bmu_wb_queue #(
    .WIDTH(WIDTH), .TAGW(TAGW), .LAT(LAT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .rd_in(rd_in),
    .result_ff(result_ff), .error(error), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_error(wb_error), .err_cnt(err_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
    logic        e;
  } ent_t;

  typedef struct {
    int          due;
    logic [4:0]  rd;
  } op_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    logic        e;
    logic        xv;
    logic [4:0]  xrd;
    logic [31:0] xd;
    logic        xe;
    logic [7:0]  xcnt;
  } vec_t;

  ent_t        mq[$];
  op_t         pipe[$];
  int          ecnt;
  bit          ovf_m;
  int          cyc;
  bit          sched_v [16];
  logic [31:0] sched_r [16];
  logic        sched_e [16];
  int          nvec;
  int          nerr;
  vec_t        tbl [6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic bit model_ir();
    return (mq.size() + pipe.size()) < DEPTH;
  endfunction

  task automatic chk_model();
    chk("issue_ready", 32'(issue_ready), 32'(model_ir()));
    chk("wb_valid", 32'(wb_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("wb_data", wb_data, mq[0].d);
      chk("wb_rd", 32'(wb_rd), 32'(mq[0].rd));
      chk("wb_error", 32'(wb_error), 32'(mq[0].e));
    end
    chk("err_cnt", 32'(err_cnt), 32'(ecnt));
    chk("ovf", 32'(ovf), 32'(ovf_m));
  endtask

  // One clock: check, drive, advance the model, wait for the next negedge.
  task automatic step(input logic v, input logic [4:0] rd,
                      input logic rdy, input logic [31:0] r,
                      input logic e);
    int          slot;
    logic [31:0] rf;
    logic        ef;
    bit          ir;
    op_t         op;
    ent_t        en;
    chk_model();
    ir   = model_ir();
    slot = cyc % 16;
    if (sched_v[slot]) begin
      rf = sched_r[slot];
      ef = sched_e[slot];
      sched_v[slot] = 1'b0;
    end else begin
      rf = $urandom;
      ef = 1'($urandom);
    end
    valid_in  = v;
    rd_in     = rd;
    wb_ready  = rdy;
    result_ff = rf;
    error     = ef;
    if (v) begin
      slot = (cyc + LAT) % 16;
      sched_v[slot] = 1'b1;
      sched_r[slot] = r;
      sched_e[slot] = e;
    end
    if (mq.size() != 0 && rdy) void'(mq.pop_front());
    if (pipe.size() != 0 && pipe[0].due == cyc) begin
      op = pipe.pop_front();
      if (ef && ecnt < 255) ecnt++;
      if (op.rd != 0) begin
        en.d = rf; en.rd = op.rd; en.e = ef;
        mq.push_back(en);
      end
    end
    if (v) begin
      if (ir) begin
        op.due = cyc + LAT; op.rd = rd;
        pipe.push_back(op);
      end else begin
        ovf_m = 1'b1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, rdy, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    wb_ready = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    pipe.delete();
    ecnt  = 0;
    ovf_m = 1'b0;
    for (int i = 0; i < 16; i++) sched_v[i] = 1'b0;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_error", 32'(wb_error), 32'd0);
  endtask

  initial begin
    nvec = 0; nerr = 0; cyc = 0; ecnt = 0; ovf_m = 1'b0;
    rst = 1'b1; valid_in = 1'b0; rd_in = '0; result_ff = '0;
    error = 1'b0; wb_ready = 1'b0;
    for (int i = 0; i < 16; i++) sched_v[i] = 1'b0;

    tbl[0] = '{5'd5,  32'hDEAD_BEEF, 1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 8'd0};
    tbl[1] = '{5'd0,  32'h1234_5678, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 8'd1};
    tbl[2] = '{5'd7,  32'hCAFE_F00D, 1'b1, 1'b1, 5'd7,  32'hCAFE_F00D, 1'b1, 8'd2};
    tbl[3] = '{5'd31, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 8'd2};
    tbl[4] = '{5'd0,  32'h0000_0000, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 8'd2};
    tbl[5] = '{5'd1,  32'h0000_0000, 1'b1, 1'b1, 5'd1,  32'h0000_0000, 1'b1, 8'd3};

    @(negedge clk);
    do_reset();

    // Single-op vectors: result appears LAT+1 cycles after issue.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, tbl[i].rd, 1'b1, tbl[i].res, tbl[i].e);
      idle(1'b0, LAT);
      chk("tbl_valid", 32'(wb_valid), 32'(tbl[i].xv));
      if (tbl[i].xv) begin
        chk("tbl_data", wb_data, tbl[i].xd);
        chk("tbl_rd", 32'(wb_rd), 32'(tbl[i].xrd));
        chk("tbl_err", 32'(wb_error), 32'(tbl[i].xe));
      end
      chk("tbl_cnt", 32'(err_cnt), 32'(tbl[i].xcnt));
      idle(1'b1, 1);
      chk("tbl_one_beat", 32'(wb_valid), 32'd0);
    end

    // Back-pressure: four ops exhaust credits, drain in order.
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 1'b0, $urandom, 1'b0);
    chk("t2_ir_low", 32'(issue_ready), 32'd0);
    idle(1'b0, LAT + 1);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_order", 32'(wb_rd), 32'(i));
      idle(1'b1, 1);
      if (i == 1) chk("t2_ir_back", 32'(issue_ready), 32'd1);
    end

    // Full queue streaming with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 5'(10 + i), 1'b0, $urandom, 1'b0);
    idle(1'b0, LAT);
    for (int i = 0; i < 16; i++) step(model_ir(), 5'(16 + i), 1'b1, $urandom, 1'b0);
    idle(1'b1, LAT + DEPTH + 1);
    chk("t4_drained", 32'(wb_valid), 32'd0);

    // Forced issue without credit, then error-count saturation.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 5'(1 + i), 1'b0, $urandom, 1'b0);
    step(1'b1, 5'd9, 1'b0, 32'h9999_9999, 1'b1);
    chk("t5_ovf", 32'(ovf), 32'd1);
    idle(1'b1, LAT + DEPTH + 2);
    chk("t5_ovf_sticky", 32'(ovf), 32'd1);
    chk("t5_no_err", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 300; i++) begin
      step(model_ir(), 5'($urandom), 1'b1, $urandom, 1'b1);
    end
    idle(1'b1, LAT + 2);
    chk("t5_sat", 32'(err_cnt), 32'd255);

    // Reset with ops queued and in flight.
    for (int i = 0; i < 3; i++) step(1'b1, 5'(3 + i), 1'b0, $urandom, 1'b1);
    do_reset();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 2) != 0), $urandom,
           1'($urandom_range(0, 3) == 0));
    end
    idle(1'b1, LAT + DEPTH + 2);
    chk_model();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
